// File: rtl/wr_pack_fsm.sv
// Byte-to-word packer: fetches bytes from a FIFO one at a time and presents
// full (or flushed partial) words on a valid/ready output.
module wr_pack_fsm #(
    parameter int unsigned OUT_WIDTH = 32,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned BYTES    = OUT_WIDTH / 8,
    localparam int unsigned CW       = $clog2(BYTES) + 1
) (
    input  logic                 axi_clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic                 i_trig,
    output logic                 read_en,
    input  logic [7:0]           i_data,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [CW-1:0]        o_byte_cnt,
    output logic                 o_partial,
    output logic [15:0]          o_word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        PRESENT
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [OUT_WIDTH-1:0] data_d;
    logic [OUT_WIDTH-1:0] shifted;
    logic [CW-1:0]        cnt_d;
    logic                 partial_d;
    logic [15:0]          words_d;
    int unsigned          lane;

    // Next-state and datapath updates; o_data doubles as the accumulator.
    always_comb begin
        state_d   = state;
        data_d    = o_data;
        cnt_d     = o_byte_cnt;
        partial_d = o_partial;
        words_d   = o_word_cnt;
        lane      = MSB_FIRST ? (BYTES - 32'(o_byte_cnt) - 32'd1) : 32'(o_byte_cnt);
        shifted   = OUT_WIDTH'(i_data) << (lane * 32'd8);

        case (state)
            IDLE: begin
                // Flush of a non-empty word wins over fetching another byte.
                if (flush && (o_byte_cnt != '0)) begin
                    state_d   = PRESENT;
                    partial_d = 1'b1;
                end else if (!fifo_empty && i_trig) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d = o_data | shifted;
                cnt_d  = o_byte_cnt + CW'(1);
                if (cnt_d == CW'(BYTES)) begin
                    state_d   = PRESENT;
                    partial_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (o_ready) begin
                    state_d   = IDLE;
                    data_d    = '0;
                    cnt_d     = '0;
                    partial_d = 1'b0;
                    words_d   = o_word_cnt + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            read_en    <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_byte_cnt <= '0;
            o_partial  <= 1'b0;
            o_word_cnt <= '0;
        end else begin
            state      <= state_d;
            read_en    <= (state_d == READ);
            o_valid    <= (state_d == PRESENT);
            o_data     <= data_d;
            o_byte_cnt <= cnt_d;
            o_partial  <= partial_d;
            o_word_cnt <= words_d;
        end
    end

endmodule

// File: tb/tb_wr_pack_fsm.sv
// Bench for wr_pack_fsm: bench-side FIFO and word model, an MSB-first and an
// LSB-first instance sharing stimulus, directed cases then random traffic.
module tb_wr_pack_fsm;

    localparam int unsigned BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        i_trig;
    logic [7:0]  i_data;
    logic        flush;
    logic        o_ready;

    logic        read_en,    read_en_l;
    logic [31:0] o_data,     o_data_l;
    logic        o_valid,    o_valid_l;
    logic [2:0]  o_byte_cnt, o_byte_cnt_l;
    logic        o_partial,  o_partial_l;
    logic [15:0] o_word_cnt, o_word_cnt_l;

    logic [7:0]  fifo_q[$];
    logic [7:0]  got[$];
    logic [15:0] exp_words;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rd    = 0;
    int          cyc     = 0;
    int          since_rd = 100;
    logic        prev_valid = 1'b0;
    logic        prev_acc   = 1'b0;

    always #5 clk = ~clk;

    wr_pack_fsm #(.OUT_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .axi_clk(clk), .rst(rst), .fifo_empty(fifo_empty), .i_trig(i_trig),
        .read_en(read_en), .i_data(i_data), .flush(flush), .o_data(o_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_byte_cnt(o_byte_cnt),
        .o_partial(o_partial), .o_word_cnt(o_word_cnt)
    );

    wr_pack_fsm #(.OUT_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .axi_clk(clk), .rst(rst), .fifo_empty(fifo_empty), .i_trig(i_trig),
        .read_en(read_en_l), .i_data(i_data), .flush(flush), .o_data(o_data_l),
        .o_valid(o_valid_l), .o_ready(o_ready), .o_byte_cnt(o_byte_cnt_l),
        .o_partial(o_partial_l), .o_word_cnt(o_word_cnt_l)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word expected from the bytes fetched so far, in arrival order.
    function automatic logic [31:0] pack(input bit msb);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < got.size() && k < BYTES; k++) begin
            if (msb) r[31-8*k -: 8] = got[k];
            else     r[8*k +: 8]    = got[k];
        end
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample strobes before the edge, then update FIFO and model.
    task automatic tick();
        logic rd;
        logic acc;
        @(posedge clk);
        rd  = read_en;
        acc = o_valid && o_ready;
        #1;
        i_data = 8'($urandom);
        if (!rst) begin
            if (acc) begin
                got.delete();
                exp_words = exp_words + 16'd1;
            end
            if (rd) begin
                n_rd++;
                chk("fifo_underflow", 64'(fifo_q.size() > 0), 64'd1);
                if (fifo_q.size() > 0) begin
                    i_data = fifo_q.pop_front();
                    got.push_back(i_data);
                end
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!o_valid && k < 100) begin
            tick();
            k++;
        end
        chk({name, "_timeout"}, 64'(o_valid), 64'd1);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            since_rd   = 100;
        end else begin
            chk("word_cnt", 64'(o_word_cnt), 64'(exp_words));
            if (prev_valid && !prev_acc) chk("valid_hold", 64'(o_valid), 64'd1);
            if (read_en) begin
                chk("rd_spacing", 64'(since_rd >= 2), 64'd1);
                chk("rd_overfill", 64'(got.size() < BYTES), 64'd1);
                since_rd = 0;
            end else if (since_rd < 100) begin
                since_rd++;
            end
            if (got.size() == BYTES && since_rd >= 2) chk("full_present", 64'(o_valid), 64'd1);
            if (o_valid) begin
                chk("valid_nonempty", 64'(got.size() > 0), 64'd1);
                chk("data_msb", 64'(o_data), 64'(pack(1'b1)));
                chk("byte_cnt", 64'(o_byte_cnt), 64'(got.size()));
                chk("partial", 64'(o_partial), 64'(got.size() < BYTES));
                chk("rd_in_present", 64'(read_en), 64'd0);
            end
            if (o_valid_l) chk("data_lsb", 64'(o_data_l), 64'(pack(1'b0)));
            prev_valid = o_valid;
            prev_acc   = o_valid && o_ready;
        end
    end

    initial begin
        int c0;
        int k;
        rst = 1'b1; fifo_empty = 1'b1; i_trig = 1'b0; i_data = 8'h00;
        flush = 1'b0; o_ready = 1'b0; exp_words = 16'h0000;
        #3;
        chk("rst_data",  64'(o_data),     64'd0);
        chk("rst_valid", 64'(o_valid),    64'd0);
        chk("rst_rd",    64'(read_en),    64'd0);
        chk("rst_cnt",   64'(o_byte_cnt), 64'd0);
        chk("rst_part",  64'(o_partial),  64'd0);
        chk("rst_words", 64'(o_word_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Full word, 3 cycles per byte.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        i_trig = 1'b1; o_ready = 1'b1; n_rd = 0; c0 = cyc;
        wait_valid("full");
        chk("full_latency", 64'(cyc - c0), 64'd12);
        chk("full_data",    64'(o_data),   64'h11223344);
        chk("full_lsb",     64'(o_data_l), 64'h44332211);
        chk("full_cnt",     64'(o_byte_cnt), 64'd4);
        chk("full_part",    64'(o_partial),  64'd0);
        chk("full_nrd",     64'(n_rd),       64'd4);
        tick();
        chk("full_words",   64'(o_word_cnt), 64'd1);
        chk("full_done",    64'(o_valid),    64'd0);

        // Partial word via flush, then flush with nothing accumulated.
        o_ready = 1'b0;
        push(8'hAA); push(8'hBB);
        repeat (10) tick();
        chk("part_idle", 64'(o_valid), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_valid("part");
        chk("part_data", 64'(o_data),     64'hAABB0000);
        chk("part_lsb",  64'(o_data_l),   64'h0000BBAA);
        chk("part_cnt",  64'(o_byte_cnt), 64'd2);
        chk("part_flag", 64'(o_partial),  64'd1);
        o_ready = 1'b1; tick();
        chk("part_done", 64'(o_valid), 64'd0);
        flush = 1'b1;
        repeat (3) begin
            tick();
            chk("empty_flush", 64'(o_valid), 64'd0);
        end
        flush = 1'b0;

        // Backpressure: word held for 5 cycles while the FIFO has more data.
        o_ready = 1'b0;
        push(8'h5A); push(8'hC3); push(8'h0F); push(8'hE1);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid("hold");
        n_rd = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_data",  64'(o_data),  64'h5AC30FE1);
            chk("hold_rd",    64'(read_en), 64'd0);
            if (i < 4) tick();
        end
        o_ready = 1'b1; tick();
        chk("hold_nrd",   64'(n_rd),       64'd0);
        chk("hold_accept", 64'(o_valid),   64'd0);
        chk("hold_words", 64'(o_word_cnt), 64'd3);
        wait_valid("next");
        chk("next_data",  64'(o_data), 64'h01020304);
        tick();

        // Asynchronous reset after 3 of 4 bytes.
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        n_rd = 0; k = 0;
        while (n_rd < 3 && k < 100) begin tick(); k++; end
        chk("mid_timeout", 64'(n_rd), 64'd3);
        tick();
        chk("mid_pre", 64'(o_data), 64'h10203000);
        #2 rst = 1'b1;
        got.delete(); fifo_q.delete(); fifo_empty = 1'b1; exp_words = 16'h0000;
        #1;
        chk("arst_data",  64'(o_data),     64'd0);
        chk("arst_cnt",   64'(o_byte_cnt), 64'd0);
        chk("arst_words", 64'(o_word_cnt), 64'd0);
        chk("arst_valid", 64'(o_valid),    64'd0);
        chk("arst_rd",    64'(read_en),    64'd0);
        chk("arst_part",  64'(o_partial),  64'd0);
        tick(); tick();
        rst = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid("post_rst");
        chk("post_rst_data", 64'(o_data), 64'h01020304);
        chk("post_rst_lsb",  64'(o_data_l), 64'h04030201);
        tick();

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            tick();
            i_trig  = ($urandom % 4) != 0;
            o_ready = ($urandom % 3) != 0;
            flush   = ($urandom % 8) == 0;
            if (fifo_q.size() < 8 && ($urandom % 2) == 1) push(8'($urandom));
        end

        // Word counter wrap, starting just below the top.
        flush = 1'b0; i_trig = 1'b1; o_ready = 1'b1;
        force dut_m.o_word_cnt = 16'hFFFE;
        force dut_l.o_word_cnt = 16'hFFFE;
        #1;
        release dut_m.o_word_cnt;
        release dut_l.o_word_cnt;
        exp_words = 16'hFFFE;
        k = 0;
        while (exp_words != 16'h0000 && k < 300) begin
            tick();
            if (fifo_q.size() < 4) push(8'($urandom));
            k++;
        end
        chk("wrap_timeout", 64'(k < 300), 64'd1);
        #1;
        chk("wrap_cnt", 64'(o_word_cnt), 64'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
